// File: rtl/p_alu_mc.sv
// p_alu_mc: multi-cycle ALU with valid/ready handshake, iterative signed MUL/DIV, registered result and flags
// Ports: clock/reset (sync, active-high); in_valid/in_ready accept an op with data_operandA/B, ctrl_ALUopcode, ctrl_shiftamt;
//        out_valid/out_ready hand off data_result, isNotEqual, isLessThan, overflow, div_by_zero.
module p_alu_mc #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = 5,
  parameter int MULDIV_EN = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q, res_d;
  logic neg_q, neg_d, div_q, div_d, bz_q, bz_d, ne_p_q, ne_p_d, lt_p_q, lt_p_d;
  logic ovf_q, ovf_d, dbz_q, dbz_d, ne_q, ne_d, lt_q, lt_d;
  logic [WIDTH-1:0] a, b, sum, dif, sra_r, sc_res, abs_a, abs_b;
  logic [4:0] op;
  logic accept, is_md, is_div, add_ovf, sub_ovf, sc_ovf;
  assign a = data_operandA;
  assign b = data_operandB;
  assign op = ctrl_ALUopcode;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept = in_valid & in_ready;
  assign is_div = op == 5'd7;
  assign is_md = (MULDIV_EN != 0) && (op == 5'd6 || is_div);
  assign sum = a + b;
  assign dif = a - b;
  assign sra_r = $signed(a) >>> ctrl_shiftamt;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;
  assign sc_res = op == 5'd1 ? dif :
                  op == 5'd2 ? a & b :
                  op == 5'd3 ? a | b :
                  op == 5'd4 ? a << ctrl_shiftamt :
                  op == 5'd5 ? sra_r :
                  op == 5'd8 ? a >> ctrl_shiftamt :
                  op == 5'd9 ? a ^ b : sum;
  assign sc_ovf = op == 5'd1 ? sub_ovf : (op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9}) ? 1'b0 : add_ovf;
  // MUL: {hi,lo} starts as {0, |mplier|}; each step conditionally adds |mcand| into hi and shifts right.
  logic [WIDTH:0] mul_sum, div_sh, div_df;
  logic [WIDTH-1:0] it_hi, it_lo, squo, mul_res, div_res;
  logic [2*WIDTH-1:0] sprod;
  logic div_ok, mul_ovf, div_ovf;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  // DIV: hi is the partial remainder, lo shifts the dividend out and the quotient bits in.
  assign div_sh = {hi_q, lo_q[WIDTH-1]};
  assign div_df = div_sh - {1'b0, m_q};
  assign div_ok = !div_df[WIDTH];
  assign it_hi = div_q ? (div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign it_lo = div_q ? {lo_q[WIDTH-2:0], div_ok} : {mul_sum[0], lo_q[WIDTH-1:1]};
  assign sprod = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
  assign mul_res = sprod[WIDTH-1:0];
  assign mul_ovf = sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}};
  assign squo = neg_q ? -it_lo : it_lo;
  assign div_res = bz_q ? '0 : squo;
  // A positive quotient with the sign bit set can only come from MIN / -1.
  assign div_ovf = !bz_q && !neg_q && squo[WIDTH-1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    neg_d = neg_q;
    div_d = div_q;
    bz_d = bz_q;
    ne_p_d = ne_p_q;
    lt_p_d = lt_p_q;
    res_d = res_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    ne_d = ne_q;
    lt_d = lt_q;
    if (accept) begin
      ne_p_d = a != b;
      lt_p_d = $signed(a) < $signed(b);
      if (is_md) begin
        state_d = BUSY;
        cnt_d = '0;
        div_d = is_div;
        neg_d = a[WIDTH-1] ^ b[WIDTH-1];
        bz_d = is_div && b == '0;
        m_d = is_div ? abs_b : abs_a;
        lo_d = is_div ? abs_a : abs_b;
        hi_d = '0;
      end else begin
        state_d = DONE;
        res_d = sc_res;
        ovf_d = sc_ovf;
        dbz_d = 1'b0;
        ne_d = a != b;
        lt_d = $signed(a) < $signed(b);
      end
    end else if (state_q == BUSY) begin
      hi_d = it_hi;
      lo_d = it_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
        state_d = DONE;
        res_d = div_q ? div_res : mul_res;
        ovf_d = div_q ? div_ovf : mul_ovf;
        dbz_d = div_q && bz_q;
        ne_d = ne_p_q;
        lt_d = lt_p_q;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      neg_q <= 1'b0;
      div_q <= 1'b0;
      bz_q <= 1'b0;
      ne_p_q <= 1'b0;
      lt_p_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
      ne_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      neg_q <= neg_d;
      div_q <= div_d;
      bz_q <= bz_d;
      ne_p_q <= ne_p_d;
      lt_p_q <= lt_p_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
      ne_q <= ne_d;
      lt_q <= lt_d;
    end
  end
  assign data_result = res_q;
  assign overflow = ovf_q;
  assign div_by_zero = dbz_q;
  assign isNotEqual = ne_q;
  assign isLessThan = lt_q;
endmodule

// File: tb/tb_p_alu_mc.sv
// tb_p_alu_mc: scoreboard bench for p_alu_mc at WIDTH=32 and WIDTH=16
module tb_p_alu_mc;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic w16 = 1'b0;
  logic [1:0] iv = '0, ordy = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] op = '0, sh = '0;
  logic ir32, ov32, ne32, lt32, of32, dz32, ir16, ov16, ne16, lt16, of16, dz16;
  logic [31:0] r32;
  logic [15:0] r16;
  logic ir, ov;
  logic [31:0] r;
  logic [3:0] fl;
  int tests = 0, fails = 0;
  p_alu_mc #(.WIDTH(32), .SHAMT_W(5), .MULDIV_EN(1)) u32 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir32),
    .data_operandA(a), .data_operandB(b), .ctrl_ALUopcode(op), .ctrl_shiftamt(sh),
    .out_valid(ov32), .out_ready(ordy[0]), .data_result(r32),
    .isNotEqual(ne32), .isLessThan(lt32), .overflow(of32), .div_by_zero(dz32));
  p_alu_mc #(.WIDTH(16), .SHAMT_W(4), .MULDIV_EN(1)) u16 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir16),
    .data_operandA(a[15:0]), .data_operandB(b[15:0]), .ctrl_ALUopcode(op), .ctrl_shiftamt(sh[3:0]),
    .out_valid(ov16), .out_ready(ordy[1]), .data_result(r16),
    .isNotEqual(ne16), .isLessThan(lt16), .overflow(of16), .div_by_zero(dz16));
  assign ir = w16 ? ir16 : ir32;
  assign ov = w16 ? ov16 : ov32;
  assign r = w16 ? {16'h0, r16} : r32;
  assign fl = w16 ? {of16, dz16, ne16, lt16} : {of32, dz32, ne32, lt32};
  typedef struct {logic [31:0] r; logic [3:0] f; int lat;} exp_t;
  exp_t sq[$];
  function automatic exp_t model(input int w, input logic [4:0] o, input logic [31:0] ai, input logic [31:0] bi, input logic [4:0] si);
    exp_t e;
    longint sa, sb, m, p, rs;
    int s;
    m = (longint'(1) << w) - 1;
    sa = w == 16 ? longint'($signed(ai[15:0])) : longint'($signed(ai));
    sb = w == 16 ? longint'($signed(bi[15:0])) : longint'($signed(bi));
    s = int'(si) & (w - 1);
    case (o)
      5'd1: p = sa - sb;
      5'd2: p = sa & sb;
      5'd3: p = sa | sb;
      5'd4: p = sa << s;
      5'd5: p = sa >>> s;
      5'd6: p = sa * sb;
      5'd7: p = sb == 0 ? 0 : sa / sb;
      5'd8: p = (sa & m) >> s;
      5'd9: p = sa ^ sb;
      default: p = sa + sb;
    endcase
    e.r = 32'(p & m);
    rs = w == 16 ? longint'($signed(e.r[15:0])) : longint'($signed(e.r));
    e.f = {(o inside {5'd0, 5'd1, 5'd6, 5'd7} || o > 5'd9) && rs != p, o == 5'd7 && sb == 0, sa != sb, sa < sb};
    e.lat = (o == 5'd6 || o == 5'd7) ? w : 0;
    return e;
  endfunction
  task automatic run_op(input logic [4:0] o, input logic [31:0] ai, input logic [31:0] bi, input logic [4:0] si, input int stall, input string nm);
    exp_t e;
    int lat;
    logic [31:0] hr;
    logic [3:0] hf;
    @(negedge clk);
    op = o; a = ai; b = bi; sh = si; iv[w16] = 1'b1;
    tests++;
    if (ir !== 1'b1) begin fails++; $display("FAIL %s in_ready got %b want 1", nm, ir); end
    sq.push_back(model(w16 ? 16 : 32, o, ai, bi, si));
    @(posedge clk); #1;
    iv = '0; a = $urandom; b = $urandom; op = 5'($urandom); sh = 5'($urandom);
    lat = 0;
    @(negedge clk);
    while (ov !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    e = sq.pop_front();
    tests++;
    if (lat !== e.lat) begin fails++; $display("FAIL %s latency got %0d want %0d", nm, lat, e.lat); end
    hr = r; hf = fl;
    for (int i = 0; i < stall; i++) begin
      iv[w16] = 1'b1;
      @(negedge clk);
      tests++;
      if (ov !== 1'b1 || ir !== 1'b0 || r !== hr || fl !== hf) begin
        fails++; $display("FAIL %s stall%0d got ov=%b ir=%b r=%h f=%b want ov=1 ir=0 r=%h f=%b", nm, i, ov, ir, r, fl, hr, hf);
      end
    end
    iv = '0; ordy[w16] = 1'b1;
    tests++;
    if (r !== e.r || fl !== e.f) begin fails++; $display("FAIL %s result got %h ovf/dbz/ne/lt=%b want %h %b", nm, r, fl, e.r, e.f); end
    @(posedge clk); #1;
    ordy = '0;
    @(negedge clk);
    tests++;
    if (ov !== 1'b0 || ir !== 1'b1) begin fails++; $display("FAIL %s release got ov=%b ir=%b want 0 1", nm, ov, ir); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || r32 !== 32'h0 || {of32, dz32, ne32, lt32} !== 4'b0) begin
      fails++; $display("FAIL reset32 got ir=%b ov=%b r=%h f=%b want 1 0 0 0", ir32, ov32, r32, {of32, dz32, ne32, lt32});
    end
    tests++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || r16 !== 16'h0 || {of16, dz16, ne16, lt16} !== 4'b0) begin
      fails++; $display("FAIL reset16 got ir=%b ov=%b r=%h f=%b want 1 0 0 0", ir16, ov16, r16, {of16, dz16, ne16, lt16});
    end
    rst = 1'b0;
  endtask
  task automatic test_reset_mid_op;
    w16 = 1'b0;
    @(negedge clk);
    op = 5'd6; a = -32'sd3; b = 32'd7; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || r32 !== 32'h0) begin
      fails++; $display("FAIL reset_mid got ov=%b ir=%b r=%h want 0 1 0", ov32, ir32, r32);
    end
    run_op(5'd0, 32'd20, 32'd22, 5'd0, 0, "add_after_reset");
  endtask
  task automatic test_add_sub;
    w16 = 1'b0;
    run_op(5'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 0, "add_ovf");
    run_op(5'd1, 32'd5, 32'd7, 5'd0, 0, "sub_5_7");
    run_op(5'd1, 32'h80000000, 32'd1, 5'd0, 0, "sub_ovf");
    run_op(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0, "and");
    run_op(5'd3, 32'hF000_0001, 32'h000F_0010, 5'd0, 0, "or");
    run_op(5'd9, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 0, "xor");
    run_op(5'd20, 32'd9, 32'd9, 5'd0, 0, "op20_add");
  endtask
  task automatic test_shifts;
    w16 = 1'b0;
    run_op(5'd5, 32'h80000000, 32'd0, 5'd31, 0, "sra31");
    run_op(5'd8, 32'h80000000, 32'd0, 5'd31, 0, "srl31");
    run_op(5'd4, 32'd1, 32'd0, 5'd0, 0, "sll0");
    run_op(5'd4, 32'h0000_00F1, 32'd0, 5'd28, 0, "sll28");
  endtask
  task automatic test_mul;
    w16 = 1'b0;
    run_op(5'd6, -32'sd3, 32'd7, 5'd0, 0, "mul_m3_7");
    run_op(5'd6, 32'h00010000, 32'h00010000, 5'd0, 0, "mul_ovf");
    run_op(5'd6, -32'sd46341, -32'sd46341, 5'd0, 0, "mul_neg_sq");
  endtask
  task automatic test_div;
    w16 = 1'b0;
    run_op(5'd7, -32'sd7, 32'd2, 5'd0, 0, "div_m7_2");
    run_op(5'd7, 32'd9, 32'd0, 5'd0, 0, "div_by_0");
    run_op(5'd7, 32'h80000000, 32'hFFFFFFFF, 5'd0, 0, "div_min_m1");
    run_op(5'd7, 32'd100, -32'sd7, 5'd0, 0, "div_100_m7");
  endtask
  task automatic test_output_stall;
    w16 = 1'b0;
    run_op(5'd1, 32'd3, 32'd10, 5'd0, 5, "stall_sub");
    run_op(5'd6, 32'd12345, -32'sd6789, 5'd0, 5, "stall_mul");
  endtask
  task automatic test_back_to_back;
    exp_t e;
    int sent = 0, got = 0, cyc = 0;
    logic acc;
    w16 = 1'b0;
    @(negedge clk);
    op = 5'd0; a = 32'd100; b = 32'd0; iv[0] = 1'b1; ordy[0] = 1'b1;
    while (got < 4 && cyc < 50) begin
      if (ov === 1'b1) begin
        tests++;
        if (sq.size() == 0) begin fails++; $display("FAIL b2b unexpected output r=%h", r); end
        else begin
          e = sq.pop_front();
          if (r !== e.r || fl !== e.f) begin fails++; $display("FAIL b2b%0d got %h %b want %h %b", got, r, fl, e.r, e.f); end
        end
        got++;
      end
      acc = iv[0] && ir;
      if (acc) sq.push_back(model(32, op, a, b, sh));
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 4) begin op = 5'd1; a = 32'd100 + sent; b = 32'd200 * sent; end
        else iv = '0;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc !== 8) begin fails++; $display("FAIL b2b cycles got %0d want 8", cyc); end
    iv = '0; ordy = '0;
    sq.delete();
  endtask
  function automatic logic [31:0] pick(input logic n16);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return n16 ? 32'h8000 : 32'h80000000;
      4: return n16 ? 32'h7FFF : 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic test_random;
    logic [4:0] o;
    for (int k = 0; k < 2; k++) begin
      w16 = k[0];
      for (int i = 0; i < 30; i++) begin
        o = $urandom_range(0, 7) == 0 ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
        run_op(o, pick(w16), pick(w16), 5'($urandom), $urandom_range(0, 2), w16 ? "rand16" : "rand32");
      end
    end
    w16 = 1'b0;
  endtask
  initial begin
    test_reset;
    test_reset_mid_op;
    test_add_sub;
    test_shifts;
    test_mul;
    test_div;
    test_output_stall;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
